alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised successor to the single-cycle datapath ALU. It executes the arithmetic, logic and compare operations in one registered cycle, and iterative multiply/divide (signed and unsigned) over WIDTH cycles into dedicated HI/LO registers. It sits in the EX stage and uses a start/busy/done handshake so the pipeline control can stall on long operations.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  operation request; sampled on rising clk edges.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 ADDU, 3 SUBU, 4 AND, 5 OR, 6 SLT (signed), 7 SLTU, 8 MULTU, 9 MULT, 10 DIVU, 11 DIV, 12–15 illegal.
- a, b  in  WIDTH  operands; captured only when a start is accepted.
- abort  in  1  cancels a running multiply/divide.
- result  out  WIDTH  registered result of single-cycle ops.
- hi, lo  out  WIDTH  multiply product high/low halves; divide remainder (hi) and quotient (lo).
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle completion pulse.
- zero  out  1  result == 0, registered with result.
- ovf  out  1  signed overflow (ADD/SUB only), registered with result.
- dz  out  1  divide by zero; valid in the done cycle of DIV/DIVU, else 0.

## Operation
- FSM states:
  - IDLE: idle state.
  - RUN: iteration counter counts WIDTH-1 down to 0.
  - FIN: sign fix-up and HI/LO write.
- Start acceptance: a start is accepted only in IDLE. A start seen while busy=1 is ignored; it is not queued.
- Single-cycle ops (0–7): computed from a/b at the accepting edge.
  - result, zero and ovf update at that edge; done=1 for the following cycle; the FSM stays in IDLE.
  - ADD/SUB wrap modulo 2^WIDTH; ovf is set on signed overflow.
  - ADDU/SUBU never set ovf.
  - SLT/SLTU write 1 or 0 to result.
- Illegal ops: result=0, zero=1, ovf=0; done pulses; hi/lo are unchanged.
- Multi-cycle ops (8–11): operands are latched and the FSM enters RUN. result, zero and ovf hold their previous values.
  - Signed ops latch absolute values and remember the result signs.
  - MULT/MULTU: shift-add multiply, one bit per cycle, 2·WIDTH-bit accumulator.
  - DIV/DIVU: restoring divide, one quotient bit per cycle.
  - After WIDTH RUN cycles, enter FIN. FIN negates as needed, writes hi/lo, pulses done, and returns to IDLE.
- Signed results:
  - MULT: hi:lo = the exact 2·WIDTH-bit two's-complement product.
  - DIV: quotient truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative / -1 gives lo = most-negative value, hi = 0. This needs no special case.
- Divide by zero (b==0): runs the full latency. Result is lo = all ones, hi = a as captured, dz=1 in the done cycle.
- abort in RUN or FIN: the next state is IDLE, busy=0 next cycle, no done, hi/lo unchanged.
- abort in IDLE: no effect. If abort and start occur in the same IDLE cycle, the start is accepted.

## Timing
- Reset (rstn low, asynchronous): FSM=IDLE, result=0, hi=0, lo=0, busy=0, done=0, zero=0, ovf=0, dz=0, counter=0.
- Reset mid-operation discards the operation completely.
- Single-cycle op latency: start accepted at edge E0 → result and done valid after E0. Back-to-back starts give one result per cycle.
- Multi-cycle op latency, start accepted at E0:
  - busy=1 after E0.
  - Iterations occur at E1..E(WIDTH).
  - FIN at E(WIDTH+1): hi/lo/dz valid, done=1, busy=0.
  - A new start is accepted in that same done cycle.
- Total multi-cycle latency is WIDTH+1 edges: 33 for WIDTH=32.
- done is never high for more than one consecutive cycle per operation.

## Test plan
- Reset release, then ADD a=0x7FFFFFFF, b=1 → result 0x80000000, ovf=1, done one cycle. Then ADDU with the same operands → ovf=0. Then SUB a=5, b=5 → result 0, zero=1.
- MULT a=0xFFFFFFFF (-1), b=0x00000002 → after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy high for exactly 33 cycles. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, dz=1 in the done cycle only.
- MULTU running with start pulsed at cycle 5 (ignored), then abort at cycle 10 → busy=0 next cycle, no done pulse, hi/lo keep their prior values. A SLTU started immediately afterwards completes in 1 cycle.
- rstn pulsed low mid-DIV → all outputs 0 asynchronously. With WIDTH=8, MULT 0x80×0x80 → hi:lo=0x4000, latency 9 edges.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with single-cycle arithmetic/logic/compare ops and
// iterative multiply/divide (signed and unsigned) writing into HI/LO.
// Long operations use a start/busy/done handshake so pipeline control can stall.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             ovf,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDU = 4'd2;
    localparam logic [3:0] OP_SUBU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Architectural outputs
    logic [WIDTH-1:0] result_reg, hi_reg, lo_reg;
    logic             done_reg, zero_reg, ovf_reg, dz_reg;

    // Iterative engine state
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd_reg;     // mul: |multiplicand|; div: |divisor|
    logic [WIDTH-1:0]   a_cap_reg;    // raw dividend, returned in HI on divide by zero
    logic               is_div_reg;
    logic               b_zero_reg;
    logic               neg_main_reg; // negate product / quotient at the end
    logic               neg_rem_reg;  // negate remainder at the end

    // FSM control strobes
    logic accept, step, commit, is_multi;

    // Single-cycle datapath
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf;

    // Operand magnitudes for the iterative ops (op[0] marks the signed variants)
    logic [WIDTH-1:0] a_abs, b_abs;

    // One-iteration results
    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] div_next;

    // Final fix-up values written to HI/LO
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign is_multi = op[3] & ~op[2];
    assign sum      = a + b;
    assign diff     = a - b;
    assign a_abs    = (op[0] && a[WIDTH-1]) ? -a : a;
    assign b_abs    = (op[0] && b[WIDTH-1]) ? -b : b;

    // State register; reset discards any operation in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // abort has no meaning here; a coincident start still goes through
                if (start) begin
                    accept = 1'b1;
                    if (is_multi) begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_reg == '0) begin
                        state_next = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
                commit     = ~abort;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Single-cycle ALU: arithmetic, logic, compares; illegal opcodes give 0
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUBU: alu_res = diff;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_upper = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_next  = {mul_upper, acc_reg[WIDTH-1:1]};

        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opnd_reg};
        if (div_trial[WIDTH+1]) begin
            // trial subtraction went negative: restore and shift in a 0
            div_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix-up of the magnitude results before they land in HI/LO
    always_comb begin
        prod_fix = neg_main_reg ? -acc_reg : acc_reg;
        fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo   = prod_fix[WIDTH-1:0];
        if (is_div_reg) begin
            if (b_zero_reg) begin
                fin_hi = a_cap_reg;
                fin_lo = '1;
            end else begin
                fin_lo = neg_main_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
                fin_hi = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Datapath registers: single-cycle results, operand capture, iteration, HI/LO write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result_reg   <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            zero_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            dz_reg       <= 1'b0;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            a_cap_reg    <= '0;
            is_div_reg   <= 1'b0;
            b_zero_reg   <= 1'b0;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
            if (accept) begin
                if (!is_multi) begin
                    result_reg <= alu_res;
                    zero_reg   <= (alu_res == '0);
                    ovf_reg    <= alu_ovf;
                    done_reg   <= 1'b1;
                end else begin
                    // op[1] selects divide; the dividend sits in the low half to be shifted out
                    acc_reg      <= op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                    opnd_reg     <= op[1] ? b_abs : a_abs;
                    cnt_reg      <= CNT_LAST;
                    a_cap_reg    <= a;
                    is_div_reg   <= op[1];
                    b_zero_reg   <= (b == '0);
                    neg_main_reg <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_reg  <= op[0] & a[WIDTH-1];
                end
            end
            if (step) begin
                acc_reg <= is_div_reg ? div_next : mul_next;
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CW'(1);
                end
            end
            if (commit) begin
                hi_reg   <= fin_hi;
                lo_reg   <= fin_lo;
                done_reg <= 1'b1;
                dz_reg   <= is_div_reg & b_zero_reg;
            end
        end
    end

    assign result = result_reg;
    assign hi     = hi_reg;
    assign lo     = lo_reg;
    assign busy   = (state_reg != S_IDLE);
    assign done   = done_reg;
    assign zero   = zero_reg;
    assign ovf    = ovf_reg;
    assign dz     = dz_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_muldiv;

    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result, hi, lo;
    logic         busy, done, zero, ovf, dz;

    logic         start8 = 1'b0;
    logic         abort8 = 1'b0;
    logic [3:0]   op8 = 4'd0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic [7:0]   result8, hi8, lo8;
    logic         busy8, done8, zero8, ovf8, dz8;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .result(result), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .zero(zero), .ovf(ovf), .dz(dz)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .op(op8), .a(a8), .b(b8), .abort(abort8),
        .result(result8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8),
        .zero(zero8), .ovf(ovf8), .dz(dz8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        multi;
    } mres_t;

    function automatic mres_t model_exec(input logic [3:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
        mres_t r;
        longint sa, sb, sr, q, rm;
        logic [63:0] p;
        r  = '0;
        sa = $signed(fa);
        sb = $signed(fb);
        case (f_op)
            4'd0: begin r.result = fa + fb; sr = sa + sb; r.ovf = (sr > MAXS) || (sr < MINS); end
            4'd1: begin r.result = fa - fb; sr = sa - sb; r.ovf = (sr > MAXS) || (sr < MINS); end
            4'd2: r.result = fa + fb;
            4'd3: r.result = fa - fb;
            4'd4: r.result = fa & fb;
            4'd5: r.result = fa | fb;
            4'd6: r.result = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: r.result = (fa < fb) ? 32'd1 : 32'd0;
            4'd8: begin r.multi = 1'b1; p = {32'b0, fa} * {32'b0, fb}; r.hi = p[63:32]; r.lo = p[31:0]; end
            4'd9: begin r.multi = 1'b1; sr = sa * sb; p = sr; r.hi = p[63:32]; r.lo = p[31:0]; end
            4'd10, 4'd11: begin
                r.multi = 1'b1;
                if (fb == 32'd0) begin
                    r.hi = fa; r.lo = 32'hFFFF_FFFF; r.dz = 1'b1;
                end else if (f_op == 4'd10) begin
                    r.lo = fa / fb; r.hi = fa % fb;
                end else begin
                    q = sa / sb; rm = sa % sb;
                    r.lo = q[31:0]; r.hi = rm[31:0];
                end
            end
            default: r.result = 32'd0;
        endcase
        if (!r.multi) r.zero = (r.result == 32'd0);
        return r;
    endfunction

    mres_t nr_w;
    assign nr_w = model_exec(op, a, b);

    mres_t       m_pend;
    logic [31:0] m_result = '0, m_hi = '0, m_lo = '0;
    logic        m_zero = 1'b0, m_ovf = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_busy = 1'b0;
    int          m_rem = 0;

    // Cycle model: a multi-cycle op completes WIDTH+1 edges after acceptance
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_result <= '0; m_hi <= '0; m_lo <= '0;
            m_zero <= 1'b0; m_ovf <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_busy <= 1'b0; m_rem <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_busy) begin
                if (abort) begin
                    m_busy <= 1'b0;
                end else if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_pend.hi;
                    m_lo   <= m_pend.lo;
                    m_dz   <= m_pend.dz;
                end else begin
                    m_rem <= m_rem - 1;
                end
            end else if (start) begin
                if (nr_w.multi) begin
                    m_busy <= 1'b1;
                    m_rem  <= W + 1;
                    m_pend <= nr_w;
                end else begin
                    m_result <= nr_w.result;
                    m_zero   <= nr_w.zero;
                    m_ovf    <= nr_w.ovf;
                    m_done   <= 1'b1;
                end
            end
        end
    end

    // Compare every output against the model each cycle out of reset
    always @(negedge clk) begin
        if (rstn) begin
            chk("m_result", result, m_result);
            chk("m_zero", zero, m_zero);
            chk("m_ovf", ovf, m_ovf);
            chk("m_hi", hi, m_hi);
            chk("m_lo", lo, m_lo);
            chk("m_busy", busy, m_busy);
            chk("m_done", done, m_done);
            chk("m_dz", dz, m_dz);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int lat, output int bcyc);
        lat  = -1;
        bcyc = busy ? 1 : 0;
        for (int n = 1; n <= max; n++) begin
            step();
            if (busy) bcyc++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic wait_done8(input int max, output int lat);
        lat = -1;
        for (int n = 1; n <= max; n++) begin
            step();
            if (done8) begin
                lat = n;
                break;
            end
        end
    endtask

    logic [3:0]  t_op  [0:7] = '{4'd1, 4'd3, 4'd6, 4'd7, 4'd4, 4'd5, 4'd13, 4'd0};
    logic [31:0] t_a   [0:7] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] t_b   [0:7] = '{32'h1, 32'h1, 32'h1, 32'h1,
                                 32'hFF00_FF00, 32'h0F0F_0000, 32'h9, 32'h8000_0000};
    logic [31:0] t_res [0:7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0,
                                 32'hF000_F000, 32'hFFFF_F0F0, 32'h0, 32'h0};
    logic        t_ovf [0:7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int lat, bc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 0); chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0); chk("rst_dz", dz, 0); chk("rst8_busy", busy8, 0);
        rstn = 1'b1;
        step();

        // back-to-back single-cycle ops
        start = 1'b1; op = 4'd0; a = 32'h7FFF_FFFF; b = 32'h1;
        step();
        chk("add_res", result, 32'h8000_0000); chk("add_ovf", ovf, 1); chk("add_done", done, 1);
        op = 4'd2;
        step();
        chk("addu_res", result, 32'h8000_0000); chk("addu_ovf", ovf, 0); chk("addu_done", done, 1);
        op = 4'd1; a = 32'd5; b = 32'd5;
        step();
        chk("sub_res", result, 0); chk("sub_zero", zero, 1); chk("sub_done", done, 1);
        start = 1'b0;
        step();
        chk("single_done_drop", done, 0);

        for (int i = 0; i < 8; i++) begin
            go(t_op[i], t_a[i], t_b[i]);
            $display("single op=%0d a=%h b=%h result=%h ovf=%0d zero=%0d", t_op[i], t_a[i], t_b[i], result, ovf, zero);
            chk("tbl_res", result, t_res[i]);
            chk("tbl_ovf", ovf, t_ovf[i]);
            chk("tbl_zero", zero, (t_res[i] == 32'd0));
            chk("tbl_done", done, 1);
        end

        // MULT -1 * 2
        go(4'd9, 32'hFFFF_FFFF, 32'h2);
        wait_done(40, lat, bc);
        $display("MULT lat=%0d busy=%0d hi=%h lo=%h", lat, bc, hi, lo);
        chk("mult_lat", lat, 33); chk("mult_busy", bc, 33);
        chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFFE);
        // accepted in the done cycle
        go(4'd8, 32'hFFFF_FFFF, 32'h2);
        wait_done(40, lat, bc);
        $display("MULTU lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("multu_lat", lat, 33); chk("multu_hi", hi, 32'h1); chk("multu_lo", lo, 32'hFFFF_FFFE);

        go(4'd11, 32'hFFFF_FFF9, 32'h2);
        wait_done(40, lat, bc);
        $display("DIV -7/2 hi=%h lo=%h", hi, lo);
        chk("div1_lo", lo, 32'hFFFF_FFFD); chk("div1_hi", hi, 32'hFFFF_FFFF);

        go(4'd11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(40, lat, bc);
        $display("DIV min/-1 hi=%h lo=%h", hi, lo);
        chk("div2_lo", lo, 32'h8000_0000); chk("div2_hi", hi, 32'h0);

        go(4'd11, 32'd7, 32'hFFFF_FFFE);
        wait_done(40, lat, bc);
        $display("DIV 7/-2 hi=%h lo=%h", hi, lo);
        chk("div3_lo", lo, 32'hFFFF_FFFD); chk("div3_hi", hi, 32'h1);

        go(4'd10, 32'h1234, 32'h0);
        wait_done(40, lat, bc);
        $display("DIVU by zero lat=%0d hi=%h lo=%h dz=%0d", lat, hi, lo, dz);
        chk("dz_lat", lat, 33); chk("dz_lo", lo, 32'hFFFF_FFFF); chk("dz_hi", hi, 32'h1234); chk("dz_flag", dz, 1);
        step();
        chk("dz_drop", dz, 0);

        go(4'd11, 32'hFFFF_FFFB, 32'h0);
        wait_done(40, lat, bc);
        $display("DIV -5 by zero hi=%h lo=%h dz=%0d", hi, lo, dz);
        chk("dzs_hi", hi, 32'hFFFF_FFFB); chk("dzs_dz", dz, 1);

        go(4'd10, 32'd100, 32'd7);
        wait_done(40, lat, bc);
        $display("DIVU 100/7 hi=%h lo=%h", hi, lo);
        chk("divu_lo", lo, 32'd14); chk("divu_hi", hi, 32'd2);

        // MULTU with an ignored start, then abort
        go(4'd8, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (3) step();
        start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
        step();
        start = 1'b0;
        chk("ign_busy", busy, 1); chk("ign_done", done, 0);
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        $display("abort RUN busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
        chk("abort_busy", busy, 0); chk("abort_done", done, 0);
        chk("abort_hi", hi, 32'd2); chk("abort_lo", lo, 32'd14);
        go(4'd7, 32'd3, 32'd5);
        chk("sltu_done", done, 1); chk("sltu_res", result, 1);

        // abort while in the fix-up cycle
        go(4'd9, 32'd5, 32'd6);
        repeat (32) step();
        chk("fin_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        $display("abort FIN busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
        chk("finab_done", done, 0); chk("finab_busy", busy, 0); chk("finab_lo", lo, 32'd14);

        // abort and start together in IDLE: start wins
        abort = 1'b1;
        go(4'd0, 32'd2, 32'd3);
        abort = 1'b0;
        chk("idleab_res", result, 32'd5); chk("idleab_done", done, 1);

        // asynchronous reset mid-divide
        go(4'd11, 32'hFFFF_FFF9, 32'h2);
        repeat (10) step();
        #2 rstn = 1'b0;
        #1;
        $display("async reset result=%h hi=%h lo=%h busy=%0d", result, hi, lo, busy);
        chk("ar_result", result, 0); chk("ar_hi", hi, 0); chk("ar_lo", lo, 0);
        chk("ar_busy", busy, 0); chk("ar_done", done, 0);
        step();
        rstn = 1'b1;
        step();
        go(4'd11, 32'hFFFF_FFF9, 32'h2);
        wait_done(40, lat, bc);
        chk("post_rst_lat", lat, 33); chk("post_rst_lo", lo, 32'hFFFF_FFFD);

        // WIDTH=8 instance
        start8 = 1'b1; op8 = 4'd9; a8 = 8'h80; b8 = 8'h80;
        step();
        start8 = 1'b0;
        wait_done8(20, lat);
        $display("W8 MULT lat=%0d hi=%h lo=%h", lat, hi8, lo8);
        chk("w8_lat", lat, 9); chk("w8_prod", {hi8, lo8}, 16'h4000);
        start8 = 1'b1; op8 = 4'd10; a8 = 8'd200; b8 = 8'd7;
        step();
        start8 = 1'b0;
        wait_done8(20, lat);
        $display("W8 DIVU lat=%0d hi=%h lo=%h", lat, hi8, lo8);
        chk("w8_div_lo", lo8, 8'h1C); chk("w8_div_hi", hi8, 8'h04);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
